stopwatch_counter: RTL and testbench

Minutes/seconds timekeeping core of the stopwatch, directly downstream of the clock divider. It samples the divider's clk_1Hz and clk_2Hz square waves as data in the clk_100MHz domain and turns their rising edges into single-cycle ticks. It maintains a BCD MM:SS count with pause and adjust modes, and feeds the display multiplexer with four BCD digits.

---
 rtl/stopwatch_counter.sv | 112 +++++++++++
 tb/tb_stopwatch_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: synchronises the divider's 1 Hz / 2 Hz square waves,
// turns their rising edges into ticks and keeps a BCD count with pause/adjust.
module stopwatch_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running
);

  localparam int unsigned TENS_W = 3;
  localparam int unsigned ONES_W = 4;
  localparam int unsigned SYNC_MSB = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] s1_sync_q, s1_sync_d;
  logic [SYNC_STAGES-1:0] s2_sync_q, s2_sync_d;
  logic                   s1_prev_q, s1_prev_d;
  logic                   s2_prev_q, s2_prev_d;
  logic                   running_q, running_d;
  logic [TENS_W-1:0]      min_tens_q, min_tens_d, sec_tens_q, sec_tens_d;
  logic [ONES_W-1:0]      min_ones_q, min_ones_d, sec_ones_q, sec_ones_d;

  logic tick_1_c, tick_2_c;
  logic count_c, adj_sec_c, adj_min_c;
  logic sec_roll_c, inc_sec_c, inc_min_c;

  // Synchronisers and rising-edge detectors
  always_comb begin
    s1_sync_d = {s1_sync_q[SYNC_STAGES-2:0], clk_1Hz};
    s2_sync_d = {s2_sync_q[SYNC_STAGES-2:0], clk_2Hz};
    s1_prev_d = s1_sync_q[SYNC_MSB];
    s2_prev_d = s2_sync_q[SYNC_MSB];
    tick_1_c  = s1_sync_q[SYNC_MSB] & ~s1_prev_q;
    tick_2_c  = s2_sync_q[SYNC_MSB] & ~s2_prev_q;
  end

  // Increment qualification: each tick is only consumed by its own mode
  always_comb begin
    count_c    = ~adj & tick_1_c & running_q;
    adj_sec_c  = adj & tick_2_c & sel;
    adj_min_c  = adj & tick_2_c & ~sel;
    sec_roll_c = (sec_ones_q == ONES_W'(9)) && (sec_tens_q == TENS_W'(5));
    inc_sec_c  = count_c | adj_sec_c;
    inc_min_c  = (count_c & sec_roll_c) | adj_min_c;
    running_d  = running_q ^ pause_pulse;
  end

  // BCD next-state for both fields; each field wraps 59 -> 00 on its own
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    if (inc_sec_c) begin
      if (sec_ones_q == ONES_W'(9)) begin
        sec_ones_d = '0;
        sec_tens_d = (sec_tens_q == TENS_W'(5)) ? '0 : sec_tens_q + TENS_W'(1);
      end else begin
        sec_ones_d = sec_ones_q + ONES_W'(1);
      end
    end
    if (inc_min_c) begin
      if (min_ones_q == ONES_W'(9)) begin
        min_ones_d = '0;
        min_tens_d = (min_tens_q == TENS_W'(5)) ? '0 : min_tens_q + TENS_W'(1);
      end else begin
        min_ones_d = min_ones_q + ONES_W'(1);
      end
    end
  end

  // Sync flops reset high so an input already high at release gives no tick
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      s1_sync_q  <= '1;
      s2_sync_q  <= '1;
      s1_prev_q  <= 1'b1;
      s2_prev_q  <= 1'b1;
      running_q  <= 1'b1;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
    end else begin
      s1_sync_q  <= s1_sync_d;
      s2_sync_q  <= s2_sync_d;
      s1_prev_q  <= s1_prev_d;
      s2_prev_q  <= s2_prev_d;
      running_q  <= running_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; digits compared as 16'hMMSS.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       clk_1hz;
  logic       clk_2hz;
  logic       pause_pulse;
  logic       adj;
  logic       sel;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;

  int total = 0;
  int bad   = 0;

  stopwatch_counter #(.SYNC_STAGES(2)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .clk_1Hz    (clk_1hz),
    .clk_2Hz    (clk_2hz),
    .pause_pulse(pause_pulse),
    .adj        (adj),
    .sel        (sel),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge on the selected divider outputs, 3 cycles high, 3 low
  task automatic pulse(input logic one, input logic two);
    clk_1hz = one;
    clk_2hz = two;
    repeat (3) @(negedge clk);
    clk_1hz = 1'b0;
    clk_2hz = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic adjust(input logic s, input int n);
    adj = 1'b1;
    sel = s;
    @(negedge clk);
    repeat (n) pulse(1'b0, 1'b1);
  endtask

  task automatic toggle_pause();
    pause_pulse = 1'b1;
    @(negedge clk);
    pause_pulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_1hz = 1'b1; clk_2hz = 1'b0;
    pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0;

    // Reset with clk_1Hz already high, then count 61 seconds
    repeat (5) @(negedge clk);
    check("reset_digits", digits(), 16'h0000);
    check("reset_running", {15'd0, running}, 16'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_tick_at_release", digits(), 16'h0000);
    clk_1hz = 1'b0;
    repeat (3) @(negedge clk);
    repeat (61) pulse(1'b1, 1'b0);
    check("count_61", digits(), 16'h0101);
    check("count_running", {15'd0, running}, 16'd1);

    // Rollover with exact latency: update lands at the second edge after sampling
    adjust(1'b0, 58);
    adjust(1'b1, 57);
    check("preset_5958", digits(), 16'h5958);
    adj = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0);
    check("roll_5959", digits(), 16'h5959);
    clk_1hz = 1'b1;
    @(negedge clk);
    check("roll_lat_k", digits(), 16'h5959);
    @(negedge clk);
    check("roll_lat_k1", digits(), 16'h5959);
    @(negedge clk);
    check("roll_0000", digits(), 16'h0000);
    clk_1hz = 1'b0;
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1);
    check("tick2_ignored_normal", digits(), 16'h0000);

    // Pause coinciding with tick_1: tick uses pre-toggle running
    repeat (5) pulse(1'b1, 1'b0);
    check("at_0005", digits(), 16'h0005);
    clk_1hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pause_pulse = 1'b1;
    @(negedge clk);
    pause_pulse = 1'b0;
    check("pause_same_cycle_digits", digits(), 16'h0006);
    check("pause_running", {15'd0, running}, 16'd0);
    clk_1hz = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2) pulse(1'b1, 1'b0);
    check("paused_hold", digits(), 16'h0006);
    toggle_pause();
    check("resume_running", {15'd0, running}, 16'd1);
    pulse(1'b1, 1'b0);
    check("resume_count", digits(), 16'h0007);

    // Adjust seconds: wraps without carry, clk_1Hz ignored
    adjust(1'b0, 12);
    adjust(1'b1, 51);
    check("preset_1258", digits(), 16'h1258);
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    check("adj_sec_1202", digits(), 16'h1202);

    // Adjust minutes while paused (pause toggled in adjust mode)
    toggle_pause();
    check("paused_in_adj", {15'd0, running}, 16'd0);
    adjust(1'b0, 46);
    adjust(1'b1, 28);
    check("preset_5830", digits(), 16'h5830);
    adjust(1'b0, 3);
    check("adj_min_0130", digits(), 16'h0130);
    check("adj_min_running", {15'd0, running}, 16'd0);

    // Reset mid-operation in adjust mode
    adjust(1'b0, 33);
    adjust(1'b1, 47);
    check("preset_3417", digits(), 16'h3417);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_digits", digits(), 16'h0000);
    check("midreset_running", {15'd0, running}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
